// File: rtl/decoder_arbiter_if.sv
// Request/grant bundle between the requesters and the shared 64-way decoder arbiter.
// master drives requests and enable; slave (the arbiter) returns the registered select.
interface decoder_arbiter_if #(
    parameter int K = 6
);
    localparam int N = 2 ** K;

    logic         arb_en;
    logic [N-1:0] req;
    logic [K-1:0] sel_idx;
    logic         sel_en;
    logic         busy;
    logic [7:0]   hold_cnt;

    modport master (
        output arb_en, req,
        input  sel_idx, sel_en, busy, hold_cnt
    );

    modport slave (
        input  arb_en, req,
        output sel_idx, sel_en, busy, hold_cnt
    );
endinterface

// File: rtl/decoder_arbiter.sv
// Round-robin arbiter sharing one decoder: registered select/enable, 1-cycle grant latency,
// bounded dwell of MAX_HOLD cycles, and a one-cycle break-before-make gap after every grant.
module decoder_arbiter #(
    parameter int K        = 6,
    parameter int MAX_HOLD = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    decoder_arbiter_if.slave  bus
);
    localparam int N = 2 ** K;

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t         state_q;
    logic [K-1:0]   ptr_q;
    logic [K-1:0]   sel_idx_q;
    logic           sel_en_q;
    logic [7:0]     hold_cnt_q;

    logic [K-1:0]   win_idx;
    logic           win_vld;
    logic [K-1:0]   cand;
    logic           grant_end;

    // Scan from the far end back toward ptr so the last hit is the closest index at or after ptr.
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int j = N - 1; j >= 0; j--) begin
            cand = ptr_q + K'(j);
            if (bus.req[cand]) begin
                win_idx = cand;
                win_vld = 1'b1;
            end
        end
    end

    assign grant_end = !bus.req[sel_idx_q] || !bus.arb_en ||
                       (hold_cnt_q == 8'(MAX_HOLD - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            sel_idx_q  <= '0;
            sel_en_q   <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE, GAP: begin
                    if (bus.arb_en && win_vld) begin
                        state_q    <= GRANT;
                        sel_idx_q  <= win_idx;
                        sel_en_q   <= 1'b1;
                        hold_cnt_q <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                GRANT: begin
                    if (grant_end) begin
                        state_q    <= GAP;
                        sel_en_q   <= 1'b0;
                        hold_cnt_q <= '0;
                        ptr_q      <= sel_idx_q + K'(1);
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.sel_idx  = sel_idx_q;
    assign bus.sel_en   = sel_en_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.hold_cnt = hold_cnt_q;
endmodule

// File: tb/tb_decoder_arbiter.sv
// Drives two arbiters (dwell 4 and dwell 2) with identical directed and random traffic
// and compares them every cycle against an owner/dwell/pointer reference model.
module tb_decoder_arbiter;
    localparam int K = 6;
    localparam int N = 64;

    logic         clk;
    logic         rst;
    logic         arb_en;
    logic [N-1:0] req;

    decoder_arbiter_if #(.K(K)) if_a ();
    decoder_arbiter_if #(.K(K)) if_b ();

    assign if_a.arb_en = arb_en;
    assign if_a.req    = req;
    assign if_b.arb_en = arb_en;
    assign if_b.req    = req;

    decoder_arbiter #(.K(K), .MAX_HOLD(4)) u_dut_a (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (if_a.slave)
    );

    decoder_arbiter #(.K(K), .MAX_HOLD(2)) u_dut_b (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (if_b.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s t=%0t got=%0d expected=%0d", tag, $time, got, exp);
    endtask

    // Reference model: who owns the decoder, for how long, and where the next search begins.
    int mh      [2] = '{4, 2};
    int m_owner [2];
    int m_dwell [2];
    int m_ptr   [2];
    int m_last  [2];
    bit m_gap   [2];

    function automatic int rr_search(input int p, input logic [N-1:0] r);
        for (int j = 0; j < N; j++)
            if (r[(p + j) % N]) return (p + j) % N;
        return -1;
    endfunction

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                m_owner[m] = -1; m_dwell[m] = 0; m_ptr[m] = 0; m_last[m] = 0; m_gap[m] = 0;
            end else if (m_owner[m] >= 0) begin
                if (!req[m_owner[m]] || !arb_en || m_dwell[m] == mh[m] - 1) begin
                    m_ptr[m]   = (m_owner[m] + 1) % N;
                    m_owner[m] = -1;
                    m_dwell[m] = 0;
                    m_gap[m]   = 1;
                end else begin
                    m_dwell[m]++;
                end
            end else begin
                m_gap[m] = 0;
                if (arb_en && req != '0) begin
                    m_owner[m] = rr_search(m_ptr[m], req);
                    m_last[m]  = m_owner[m];
                    m_dwell[m] = 0;
                end
            end
        end
    endtask

    task automatic compare();
        logic [K-1:0] g_idx [2];
        logic         g_en  [2];
        logic         g_bsy [2];
        logic [7:0]   g_hc  [2];
        g_idx[0] = if_a.sel_idx; g_en[0] = if_a.sel_en; g_bsy[0] = if_a.busy; g_hc[0] = if_a.hold_cnt;
        g_idx[1] = if_b.sel_idx; g_en[1] = if_b.sel_en; g_bsy[1] = if_b.busy; g_hc[1] = if_b.hold_cnt;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("sel_en[mh%0d]", mh[m]), g_en[m], (m_owner[m] >= 0) ? 1 : 0);
            chk($sformatf("sel_idx[mh%0d]", mh[m]), g_idx[m], m_last[m]);
            chk($sformatf("busy[mh%0d]", mh[m]), g_bsy[m], (m_owner[m] >= 0 || m_gap[m]) ? 1 : 0);
            chk($sformatf("hold_cnt[mh%0d]", mh[m]), g_hc[m], (m_owner[m] >= 0) ? m_dwell[m] : 0);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            compare();
        end
    endtask

    function automatic logic [N-1:0] rand_req();
        logic [N-1:0] r;
        r = '0;
        for (int b = 0; b < int'($urandom_range(0, 4)); b++)
            r[$urandom_range(0, N - 1)] = 1'b1;
        return r;
    endfunction

    initial begin
        rst = 1'b1; arb_en = 1'b1; req = '0;
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = -1; m_dwell[m] = 0; m_ptr[m] = 0; m_last[m] = 0; m_gap[m] = 0;
        end
        step(2);
        rst = 1'b0;
        step(1);

        // single request
        req = '0; req[5] = 1'b1;  step(3);
        req = '0;                  step(4);

        // round-robin among 3, 10, 63
        req[3] = 1'b1; req[10] = 1'b1; req[63] = 1'b1; step(24);

        // wrap-around after a grant to 63
        req = '0; req[63] = 1'b1; step(5);
        req = '0; req[0] = 1'b1; req[62] = 1'b1; step(14);
        req = '0; step(3);

        // release coinciding with timeout on the short-dwell instance
        req[7] = 1'b1; step(2);
        req = '0;      step(3);

        // arb_en dropped mid-grant, then re-enabled
        req[9] = 1'b1; step(2);
        arb_en = 1'b0; req[10] = 1'b1; req[12] = 1'b1; step(5);
        arb_en = 1'b1; step(10);
        req = '0; step(3);

        // reset mid-grant, then search restarts from 0
        req[20] = 1'b1; step(2);
        rst = 1'b1;     step(1);
        rst = 1'b0; req = '0; req[5] = 1'b1; req[40] = 1'b1; step(12);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = rand_req();
            else if ($urandom_range(0, 7) == 0) req[$urandom_range(0, N - 1)] = 1'b0;
            arb_en = ($urandom_range(0, 19) != 0);
            rst    = ($urandom_range(0, 199) == 0);
            step(1);
        end
        rst = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
